// File: rtl/axis_rr_packet_arbiter.sv
// Purpose : packet-granular round-robin arbiter sharing one AXI4-Stream channel among N masters,
//           plus a combinational demux of the response stream back to the requesters by r_tid.
// Latency : 1 bubble cycle per packet for arbitration, then 1 cycle s->m per beat (full throughput).
// Backpr. : s_tready[grant] = !m_tvalid | m_tready; output register holds while m_tvalid & !m_tready.
// Ports   : clk/_rst           clock, async active-low reset
//           s_t*  (N lanes)    requester streams in, s_tready back
//           m_t*               registered shared stream out, m_tid = source index
//           r_t*               response stream from the shared slave, routed by r_tid
//           o_t*  (N lanes)    response streams to requesters
module axis_rr_packet_arbiter #(
  parameter int N   = 4,
  parameter int DSZ = 8,
  localparam int IDW = ($clog2(N) < 1) ? 1 : $clog2(N)
) (
  input  logic             clk,
  input  logic             _rst,
  input  logic [N*DSZ-1:0] s_tdata,
  input  logic [N-1:0]     s_tvalid,
  output logic [N-1:0]     s_tready,
  input  logic [N-1:0]     s_tlast,
  output logic [DSZ-1:0]   m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [IDW-1:0]   m_tid,
  input  logic [DSZ-1:0]   r_tdata,
  input  logic             r_tvalid,
  output logic             r_tready,
  input  logic             r_tlast,
  input  logic [IDW-1:0]   r_tid,
  output logic [N*DSZ-1:0] o_tdata,
  output logic [N-1:0]     o_tvalid,
  input  logic [N-1:0]     o_tready,
  output logic [N-1:0]     o_tlast
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   r_last_grant;
  logic             r_m_tvalid;
  logic [DSZ-1:0]   r_m_tdata;
  logic             r_m_tlast;
  logic [IDW-1:0]   r_m_tid;

  logic [IDW-1:0]   w_winner;
  logic             w_any;
  logic             w_beat_rdy;
  logic             w_accept;

  assign w_any      = |s_tvalid;
  // Output register can take a new beat when empty or draining this cycle.
  assign w_beat_rdy = !r_m_tvalid || m_tready;
  assign w_accept   = (r_state == BUSY) && w_beat_rdy && s_tvalid[r_grant];

  // Round-robin scan starting just after the last winner. Iterating from the
  // farthest candidate down to the nearest lets the nearest requester win.
  always_comb begin
    w_winner = '0;
    for (int k = N; k >= 1; k--) begin
      if (s_tvalid[(int'(r_last_grant) + k) % N]) begin
        w_winner = IDW'((int'(r_last_grant) + k) % N);
      end
    end
  end

  always_comb begin
    s_tready = '0;
    if (r_state == BUSY) begin
      s_tready[r_grant] = w_beat_rdy;
    end
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= IDW'(N - 1);
      r_m_tvalid   <= 1'b0;
      r_m_tdata    <= '0;
      r_m_tlast    <= 1'b0;
      r_m_tid      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= BUSY;
          end
        end
        BUSY: begin
          if (w_accept && s_tlast[r_grant]) begin
            r_state <= IDLE;
          end
        end
      endcase

      // A new beat overrides the drain so back-to-back beats keep m_tvalid high.
      if (w_accept) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= s_tdata[int'(r_grant)*DSZ +: DSZ];
        r_m_tlast  <= s_tlast[r_grant];
        r_m_tid    <= r_grant;
      end else if (r_m_tvalid && m_tready) begin
        r_m_tvalid <= 1'b0;
      end
    end
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tlast  = r_m_tlast;
  assign m_tid    = r_m_tid;

  // Response demux: data/last fan out to every lane, only the addressed lane
  // sees valid. An r_tid with no matching lane is sunk (ready held high).
  assign o_tdata = {N{r_tdata}};
  assign o_tlast = {N{r_tlast}};

  always_comb begin
    o_tvalid = '0;
    r_tready = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (r_tid == IDW'(i)) begin
        o_tvalid[i] = r_tvalid;
        r_tready    = o_tready[i];
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
module tb_axis_rr_packet_arbiter;

  localparam int N   = 4;
  localparam int DSZ = 8;

  logic             clk;
  logic             rst_n;
  logic [N*DSZ-1:0] s_tdata;
  logic [N-1:0]     s_tvalid;
  logic [N-1:0]     s_tready;
  logic [N-1:0]     s_tlast;
  logic [DSZ-1:0]   m_tdata;
  logic             m_tvalid;
  logic             m_tready;
  logic             m_tlast;
  logic [1:0]       m_tid;
  logic [DSZ-1:0]   r_tdata;
  logic             r_tvalid;
  logic             r_tready;
  logic             r_tlast;
  logic [1:0]       r_tid;
  logic [N*DSZ-1:0] o_tdata;
  logic [N-1:0]     o_tvalid;
  logic [N-1:0]     o_tready;
  logic [N-1:0]     o_tlast;

  // Second instance with N=5 so that an r_tid beyond the last lane is representable.
  logic [5*DSZ-1:0] s5_tdata;
  logic [4:0]       s5_tvalid;
  logic [4:0]       s5_tready;
  logic [4:0]       s5_tlast;
  logic [DSZ-1:0]   m5_tdata;
  logic             m5_tvalid;
  logic             m5_tlast;
  logic [2:0]       m5_tid;
  logic             r5_tvalid;
  logic             r5_tready;
  logic [2:0]       r5_tid;
  logic [5*DSZ-1:0] o5_tdata;
  logic [4:0]       o5_tvalid;
  logic [4:0]       o5_tready;
  logic [4:0]       o5_tlast;

  axis_rr_packet_arbiter #(.N(N), .DSZ(DSZ)) u_dut (
    .clk(clk), ._rst(rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast), .m_tid(m_tid),
    .r_tdata(r_tdata), .r_tvalid(r_tvalid), .r_tready(r_tready), .r_tlast(r_tlast), .r_tid(r_tid),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready), .o_tlast(o_tlast)
  );

  axis_rr_packet_arbiter #(.N(5), .DSZ(DSZ)) u_dut5 (
    .clk(clk), ._rst(rst_n),
    .s_tdata(s5_tdata), .s_tvalid(s5_tvalid), .s_tready(s5_tready), .s_tlast(s5_tlast),
    .m_tdata(m5_tdata), .m_tvalid(m5_tvalid), .m_tready(1'b1), .m_tlast(m5_tlast), .m_tid(m5_tid),
    .r_tdata(r_tdata), .r_tvalid(r5_tvalid), .r_tready(r5_tready), .r_tlast(r_tlast), .r_tid(r5_tid),
    .o_tdata(o5_tdata), .o_tvalid(o5_tvalid), .o_tready(o5_tready), .o_tlast(o5_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         gap;
  } beat_t;

  typedef struct {
    logic [1:0] tid;
    logic [7:0] d;
    logic       l;
  } exp_t;

  beat_t src_q [N][$];
  exp_t  sb_q[$];
  int    hs_cyc[$];
  int    cyc;
  int    checks;
  int    errors;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Queue a packet on a requester and its expected output beats on the scoreboard.
  // The bench calls this in the order the round-robin arbiter must serve the packets.
  task automatic send_pkt(input int port, input logic [7:0] first, input int len,
                          input int gap_at, input int gap_len);
    beat_t b;
    exp_t  e;
    for (int j = 0; j < len; j++) begin
      b.d   = first + 8'(j);
      b.l   = (j == len - 1);
      b.gap = (j == gap_at) ? gap_len : 0;
      src_q[port].push_back(b);
      e.tid = 2'(port);
      e.d   = b.d;
      e.l   = b.l;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", tag}, sb_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Requester model: presents queue heads, pops on handshake, honours per-beat gaps.
  initial begin
    logic [N-1:0] hs;
    beat_t        b;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    forever begin
      @(negedge clk);
      hs = s_tvalid & s_tready;
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (hs[i]) void'(src_q[i].pop_front());
        s_tvalid[i] = 1'b0;
        if (src_q[i].size() != 0) begin
          b = src_q[i][0];
          if (b.gap > 0) begin
            b.gap--;
            src_q[i][0] = b;
          end else begin
            s_tvalid[i]           = 1'b1;
            s_tdata[i*DSZ +: DSZ] = b.d;
            s_tlast[i]            = b.l;
          end
        end
      end
    end
  end

  // Output monitor: every transferred beat is popped and compared in order.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      chk("sb_has_entry", (sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("m_tid", m_tid, e.tid);
        chk("m_tdata", m_tdata, e.d);
        chk("m_tlast", m_tlast, e.l);
        hs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    m_tready  = 1'b1;
    r_tdata   = '0;
    r_tvalid  = 1'b0;
    r_tlast   = 1'b0;
    r_tid     = '0;
    o_tready  = '0;
    s5_tdata  = '0;
    s5_tvalid = '0;
    s5_tlast  = '0;
    r5_tvalid = 1'b0;
    r5_tid    = '0;
    o5_tready = '0;

    // Reset with every requester holding packets: 0,1,2,3 then a second from 0.
    send_pkt(0, 8'h01, 2, -1, 0);
    send_pkt(1, 8'h03, 2, -1, 0);
    send_pkt(2, 8'h05, 2, -1, 0);
    send_pkt(3, 8'h07, 2, -1, 0);
    send_pkt(0, 8'h09, 2, -1, 0);
    repeat (4) @(negedge clk);
    chk("rst_s_tvalid_driven", s_tvalid, 4'hF);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_o_tvalid", o_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tid", m_tid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin order checked by the scoreboard; spacing checked here.
    drain("rr", 200);
    chk("rr_beats", hs_cyc.size(), 10);
    if (hs_cyc.size() == 10) begin
      for (int p = 0; p < 5; p++) chk("rr_in_pkt_consec", hs_cyc[2*p+1] - hs_cyc[2*p], 1);
      for (int p = 1; p < 5; p++) chk("rr_one_bubble", hs_cyc[2*p] - hs_cyc[2*p-1], 2);
    end

    // Port 2 alone, 8-beat packet at full throughput.
    hs_cyc.delete();
    send_pkt(2, 8'h11, 8, -1, 0);
    drain("p2", 100);
    chk("p2_beats", hs_cyc.size(), 8);
    if (hs_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++) chk("p2_consec", hs_cyc[i] - hs_cyc[i-1], 1);
    end

    // Backpressure mid-packet on port 0: 0x21 transfers, 0x22 is held for 3 cycles.
    send_pkt(0, 8'h21, 4, -1, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_tvalid && n < 50);
    chk("bp_start", m_tvalid, 1);
    @(posedge clk);
    #1 m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_m_tvalid", m_tvalid, 1);
      chk("bp_m_tdata", m_tdata, 8'h22);
      chk("bp_m_tlast", m_tlast, 0);
      chk("bp_m_tid", m_tid, 0);
      chk("bp_s_tready", s_tready, 0);
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    drain("bp", 100);

    // Port 1 stalls 2 cycles mid-packet while port 3 waits for its tlast.
    send_pkt(1, 8'h31, 4, 2, 2);
    send_pkt(3, 8'h41, 2, -1, 0);
    drain("hold", 100);

    // Response demux.
    @(negedge clk);
    r_tvalid = 1'b1;
    r_tid    = 2'd1;
    r_tdata  = 8'hA5;
    r_tlast  = 1'b1;
    o_tready = 4'b1101;
    #1;
    chk("rsp_o_tvalid", o_tvalid, 4'b0010);
    chk("rsp_o_tdata1", o_tdata[15:8], 8'hA5);
    chk("rsp_o_tlast1", o_tlast[1], 1);
    chk("rsp_rdy_low", r_tready, 0);
    o_tready = 4'b0010;
    #1;
    chk("rsp_rdy_high", r_tready, 1);
    r_tid    = 2'd2;
    o_tready = 4'b0000;
    #1;
    chk("rsp_o_tvalid2", o_tvalid, 4'b0100);
    chk("rsp_rdy_tid2", r_tready, 0);
    r_tvalid = 1'b0;
    #1;
    chk("rsp_idle", o_tvalid, 0);

    r5_tvalid = 1'b1;
    r5_tid    = 3'd5;
    o5_tready = 5'b00000;
    #1;
    chk("sink_rdy", r5_tready, 1);
    chk("sink_o_tvalid", o5_tvalid, 0);
    r5_tid = 3'd3;
    #1;
    chk("n5_tid3_rdy", r5_tready, 0);
    chk("n5_tid3_o_tvalid", o5_tvalid, 5'b01000);
    r5_tvalid = 1'b0;

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
